lsu_mem_adapter: RTL and testbench

// - Load/store adapter between the RV32I execute stage and the word-wide data memory (32-bit async-read, sync-write RAM, no byte enables).
// - Does RV32I byte/half/word load extraction with sign/zero extension.
// - Sub-word stores use a two-cycle read-modify-write: read old word, merge into a register, then write.
// - One request in flight; valid/ready request side, single-cycle response pulse.

---
 rtl/lsu_mem_adapter.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_adapter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_adapter.sv
// RV32I load/store adapter onto a word-wide async-read/sync-write RAM; sub-word stores use read-modify-write.
// Optional: define LSU_MISALIGN_TRAP_EN to report misaligned LH/LHU/SH/LW/SW as errors instead of aligning them.
module lsu_mem_adapter #(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   mem_wdata,
  output logic          mem_we
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state;
  logic        cap_we;
  logic [2:0]  cap_f3;
  logic [1:0]  cap_lo;
  logic [15:0] cap_wdata;
  logic        cap_err;

  logic        req_illegal;
  logic        req_misalign;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merge_val;
  logic        unused_addr_bits;

  assign req_ready        = (state == IDLE);
  assign unused_addr_bits = ^req_addr[31:AW+2];

  always_comb begin
    req_illegal = 1'b1;
    if (req_we)
      req_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      req_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    req_misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01)
      req_misalign = req_addr[0];
    else if (req_funct3[1:0] == 2'b10)
      req_misalign = |req_addr[1:0];
`endif
    req_err = req_illegal | req_misalign;
  end

  // Half lanes use only addr[1] and words ignore addr[1:0], which is what aligns
  // misaligned accesses when the trap is not built in.
  always_comb begin
    lane_b = mem_rdata[{cap_lo, 3'b000} +: 8];
    lane_h = mem_rdata[{cap_lo[1], 4'b0000} +: 16];
    case (cap_f3)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_val = mem_rdata;
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = '0;
    endcase
    merge_val = mem_rdata;
    if (cap_f3[1:0] == 2'b00)
      merge_val[{cap_lo, 3'b000} +: 8] = cap_wdata[7:0];
    else
      merge_val[{cap_lo[1], 4'b0000} +: 16] = cap_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cap_we     <= 1'b0;
      cap_f3     <= '0;
      cap_lo     <= '0;
      cap_wdata  <= '0;
      cap_err    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_f3    <= req_funct3;
            cap_lo    <= req_addr[1:0];
            cap_wdata <= req_wdata[15:0];
            cap_err   <= req_err;
            mem_addr  <= req_addr[AW+1:2];
            mem_wdata <= req_wdata;
            // A full-word store writes during ACCESS, so its enable is set on accept.
            mem_we    <= req_we && (req_funct3 == 3'b010) && !req_err;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (cap_err) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (!cap_we) begin
            resp_rdata <= load_val;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (cap_f3 == 3'b010) begin
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            mem_wdata <= merge_val;
            mem_we    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Self-checking bench for lsu_mem_adapter: directed vector table, random ops against a reference model, reset-in-flight sequence.
module tb_lsu_mem_adapter;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [31:0]   mem_wdata;
  logic          mem_we;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_adapter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the RV32I access rules.
  task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output logic [7:0] mask);
    int unsigned idx, bofs, size, lo;
    longint unsigned word, v, m;
    logic legal, mis;
    idx  = (addr / 4) % DEPTH;
    bofs = addr % 4;
    word = longint'(ref_mem[idx]);
    size = 1 << (f3 % 4);
    legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = legal && ((addr % size) != 0);
`else
    mis = 1'b0;
`endif
    rd = '0; er = 1'b0; lat = 2; mask = '0;
    if (!legal || mis) begin
      er = 1'b1;
    end else if (!we) begin
      if (size == 4) begin
        rd = word[31:0];
      end else begin
        lo = (bofs / size) * size;
        v = (word >> (8 * lo)) % (64'd1 << (8 * size));
        if (f3 < 4 && v >= (64'd1 << (8 * size - 1))) v = v + 64'h1_0000_0000 - (64'd1 << (8 * size));
        rd = v[31:0];
      end
    end else if (size == 4) begin
      ref_mem[idx] = wd;
      mask = 8'b0000_0010;
    end else begin
      lo = (bofs / size) * size;
      m = ((64'd1 << (8 * size)) - 1) << (8 * lo);
      v = (word & ~m) | ((longint'(wd) << (8 * lo)) & m);
      ref_mem[idx] = v[31:0];
      lat = 3;
      mask = 8'b0000_0100;
    end
  endtask

  // Issue one request and observe it cycle by cycle; bit k of we_mask is mem_we in cycle T+k.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output logic [7:0] we_mask, output logic busy_ok);
    rd = '0; er = 1'b0; lat = 0; we_mask = '0; busy_ok = 1'b1;
    @(negedge clk);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      we_mask[k] = mem_we;
      if (req_ready) busy_ok = 1'b0;
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err; lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic [7:0]  mask;
    logic [31:0] mem_after;
  } vec_t;

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                              logic [31:0] rd, logic err, int lat, logic [7:0] mask, logic [31:0] ma);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.err = err;
    v.lat = lat; v.mask = mask; v.mem_after = ma;
    return v;
  endfunction

  initial begin
    vec_t tbl [18];
    logic [31:0] rd, exp_rd, saved;
    logic er, exp_er, busy_ok;
    int lat, exp_lat;
    logic [7:0] msk, exp_msk;
    int unsigned idx;
    logic [31:0] addr;

    tbl[0]  = mk(1, 3'b010, 32'h10, 32'h8899AABB, 32'h0, 0, 2, 8'b010, 32'h8899AABB);
    tbl[1]  = mk(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 2, 8'b000, 32'h8899AABB);
    tbl[2]  = mk(0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 0, 2, 8'b000, 32'h8899AABB);
    tbl[3]  = mk(0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 0, 2, 8'b000, 32'h8899AABB);
    tbl[4]  = mk(0, 3'b101, 32'h12, 32'h0, 32'h00008899, 0, 2, 8'b000, 32'h8899AABB);
    tbl[5]  = mk(1, 3'b000, 32'h12, 32'h12345655, 32'h0, 0, 3, 8'b100, 32'h8855AABB);
    tbl[6]  = mk(0, 3'b010, 32'h10, 32'h0, 32'h8855AABB, 0, 2, 8'b000, 32'h8855AABB);
    tbl[7]  = mk(1, 3'b010, 32'h10, 32'h8899AABB, 32'h0, 0, 2, 8'b010, 32'h8899AABB);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[8]  = mk(1, 3'b001, 32'h11, 32'h0000CAFE, 32'h0, 1, 2, 8'b000, 32'h8899AABB);
    tbl[9]  = mk(0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 0, 2, 8'b000, 32'h8899AABB);
    tbl[15] = mk(0, 3'b010, 32'h13, 32'h0, 32'h0, 1, 2, 8'b000, 32'hDEADBEEF);
`else
    tbl[8]  = mk(1, 3'b001, 32'h11, 32'h0000CAFE, 32'h0, 0, 3, 8'b100, 32'h8899CAFE);
    tbl[9]  = mk(0, 3'b010, 32'h10, 32'h0, 32'h8899CAFE, 0, 2, 8'b000, 32'h8899CAFE);
    tbl[15] = mk(0, 3'b010, 32'h13, 32'h0, 32'hDEADBEEF, 0, 2, 8'b000, 32'hDEADBEEF);
`endif
    tbl[10] = mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 8'b010, 32'hDEADBEEF);
    tbl[11] = mk(0, 3'b010, 32'h1010, 32'h0, 32'hDEADBEEF, 0, 2, 8'b000, 32'hDEADBEEF);
    tbl[12] = mk(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 2, 8'b000, 32'hDEADBEEF);
    tbl[13] = mk(1, 3'b011, 32'h10, 32'h0, 32'h0, 1, 2, 8'b000, 32'hDEADBEEF);
    tbl[14] = mk(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 2, 8'b000, 32'hDEADBEEF);
    tbl[16] = mk(0, 3'b110, 32'h10, 32'h0, 32'h0, 1, 2, 8'b000, 32'hDEADBEEF);
    tbl[17] = mk(1, 3'b000, 32'h1013, 32'h00000077, 32'h0, 0, 3, 8'b100, 32'h77ADBEEF);

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, er, lat, msk, busy_ok);
      ref_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, exp_rd, exp_er, exp_lat, exp_msk);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].err});
      chk($sformatf("vec%0d_we_cycles", i), {24'd0, msk}, {24'd0, tbl[i].mask});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy_ok}, 32'd1);
      chk($sformatf("vec%0d_mem", i), mem[4], tbl[i].mem_after);
    end

    for (int i = 0; i < 8; i++) begin
      addr = i * 4;
      run_req(1'b1, 3'b010, addr, $urandom, rd, er, lat, msk, busy_ok);
      ref_op(1'b1, 3'b010, addr, req_wdata, exp_rd, exp_er, exp_lat, exp_msk);
      chk("init_mem", mem[i], ref_mem[i]);
    end

    for (int n = 0; n < 300; n++) begin
      logic rwe;
      logic [2:0] rf3;
      logic [31:0] rwd;
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      rwd = $urandom;
      idx = $urandom_range(0, 7);
      addr = ($urandom & 32'hFFFF_F003) | (idx << 2);
      run_req(rwe, rf3, addr, rwd, rd, er, lat, msk, busy_ok);
      ref_op(rwe, rf3, addr, rwd, exp_rd, exp_er, exp_lat, exp_msk);
      chk("rnd_lat", lat, exp_lat);
      chk("rnd_rdata", rd, exp_rd);
      chk("rnd_err", {31'd0, er}, {31'd0, exp_er});
      chk("rnd_we_cycles", {24'd0, msk}, {24'd0, exp_msk});
      chk("rnd_busy", {31'd0, busy_ok}, 32'd1);
      chk("rnd_mem", mem[idx], ref_mem[idx]);
    end

    // Reset asserted while a byte store sits in WRITE: the merge must never reach memory.
    saved = ref_mem[4];
    @(negedge clk);
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h12; req_wdata = 32'h000000EE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstw_we_before", {31'd0, mem_we}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstw_we_async", {31'd0, mem_we}, 32'd0);
    chk("rstw_resp_async", {31'd0, resp_valid}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstw_resp_held", {31'd0, resp_valid}, 32'd0);
      chk("rstw_we_held", {31'd0, mem_we}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_ready_after", {31'd0, req_ready}, 32'd1);
    chk("rstw_resp_after", {31'd0, resp_valid}, 32'd0);
    chk("rstw_mem", mem[4], saved);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
